// File: rtl/fluid_pio_pulse_sequencer_if.sv
// Avalon-MM write-only bus between the pulse sequencer (master) and the
// fluid-board output PIO (slave).
interface fluid_pio_pulse_sequencer_if;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [31:0] av_writedata;
  logic        av_waitrequest;

  modport master (
    output av_address, av_chipselect, av_write_n, av_writedata,
    input  av_waitrequest
  );

  modport slave (
    input  av_address, av_chipselect, av_write_n, av_writedata,
    output av_waitrequest
  );
endinterface

// File: rtl/fluid_pio_pulse_sequencer.sv
// Timed pulse engine for the fluid-board PIO: per-channel set/hold/clear
// sequencing, round-robin arbitration and a single-outstanding Avalon write master.
module fluid_pio_pulse_sequencer #(
  parameter int NCH      = 4,
  parameter int DW       = 16,
  parameter int PRESCALE = 50000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  // Request handshake: a request is taken on any rising edge where
  // i_req_valid[i] && o_req_ready[i]; o_req_ready[i] is high only in IDLE.
  input  logic [NCH-1:0]            i_req_valid,
  output logic [NCH-1:0]            o_req_ready,
  input  logic [NCH*16-1:0]         i_req_mask,
  input  logic [NCH*DW-1:0]         i_req_dur,
  input  logic                      i_abort,
  output logic [NCH-1:0]            o_busy,
  output logic [NCH-1:0]            o_done,
  output logic [2*NCH-1:0]          o_dbg_ch_state,
  output logic [1:0]                o_dbg_wr_state,
  fluid_pio_pulse_sequencer_if.master av
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {CH_IDLE, CH_SET_PEND, CH_ACTIVE, CH_CLR_PEND} ch_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_BUSY, WR_DEASSERT} wr_state_t;

  ch_state_t       r_ch_state [NCH];
  logic [15:0]     r_mask     [NCH];
  logic [DW-1:0]   r_dur      [NCH];
  logic [DW-1:0]   r_cnt      [NCH];
  logic [NCH-1:0]  r_abort_hit;
  logic [NCH-1:0]  r_done;
  wr_state_t       r_wr_state;
  logic [PW-1:0]   r_wr_ch;
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_presc;
  logic [2:0]      r_av_address;
  logic            r_av_chipselect;
  logic            r_av_write_n;
  logic [31:0]     r_av_writedata;

  logic            w_tick;
  logic            w_accept;
  logic [NCH-1:0]  w_req;
  logic            w_grant_any;
  logic [PW-1:0]   w_grant_ch;
  logic            w_grant_set;
  logic [PW:0]     w_idx;

  assign w_tick   = (r_presc == CW'(PRESCALE - 1));
  assign w_accept = (r_wr_state == WR_BUSY) && !av.av_waitrequest;

  // An abort withdraws ungranted set requests in the same cycle.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_ch  = '0;
    w_idx       = '0;
    for (int i = 0; i < NCH; i++)
      w_req[i] = ((r_ch_state[i] == CH_SET_PEND) && !i_abort) || (r_ch_state[i] == CH_CLR_PEND);
    for (int k = 0; k < NCH; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NCH)) w_idx = w_idx - (PW+1)'(NCH);
      if (!w_grant_any && w_req[w_idx[PW-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_ch  = w_idx[PW-1:0];
      end
    end
    w_grant_set = (r_ch_state[w_grant_ch] == CH_SET_PEND);
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      o_req_ready[i]            = (r_ch_state[i] == CH_IDLE);
      o_busy[i]                 = (r_ch_state[i] != CH_IDLE);
      o_dbg_ch_state[2*i +: 2]  = r_ch_state[i];
    end
  end

  assign o_done           = r_done;
  assign o_dbg_wr_state   = r_wr_state;
  assign av.av_address    = r_av_address;
  assign av.av_chipselect = r_av_chipselect;
  assign av.av_write_n    = r_av_write_n;
  assign av.av_writedata  = r_av_writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc         <= '0;
      r_ptr           <= '0;
      r_wr_state      <= WR_IDLE;
      r_wr_ch         <= '0;
      r_av_address    <= '0;
      r_av_chipselect <= 1'b0;
      r_av_write_n    <= 1'b1;
      r_av_writedata  <= '0;
      r_done          <= '0;
      r_abort_hit     <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_ch_state[i] <= CH_IDLE;
        r_mask[i]     <= '0;
        r_dur[i]      <= '0;
        r_cnt[i]      <= '0;
      end
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;

      // One write at a time: grant, hold until accepted, one idle cycle.
      case (r_wr_state)
        WR_IDLE: if (w_grant_any) begin
          r_wr_state      <= WR_BUSY;
          r_wr_ch         <= w_grant_ch;
          r_ptr           <= (w_grant_ch == PW'(NCH - 1)) ? '0 : w_grant_ch + 1'b1;
          r_av_chipselect <= 1'b1;
          r_av_write_n    <= 1'b0;
          r_av_address    <= w_grant_set ? 3'd4 : 3'd5;
          r_av_writedata  <= {16'h0000, r_mask[w_grant_ch]};
        end
        WR_BUSY: if (!av.av_waitrequest) begin
          r_wr_state      <= WR_DEASSERT;
          r_av_chipselect <= 1'b0;
          r_av_write_n    <= 1'b1;
        end
        default: r_wr_state <= WR_IDLE;
      endcase

      for (int i = 0; i < NCH; i++) begin
        r_done[i] <= 1'b0;
        case (r_ch_state[i])
          CH_IDLE: if (i_req_valid[i]) begin
            r_mask[i]      <= i_req_mask[16*i +: 16];
            r_dur[i]       <= i_req_dur[DW*i +: DW];
            r_abort_hit[i] <= 1'b0;
            r_ch_state[i]  <= CH_SET_PEND;
          end
          CH_SET_PEND: begin
            if (w_accept && (r_wr_ch == PW'(i))) begin
              if ((r_dur[i] == '0) || i_abort || r_abort_hit[i]) begin
                r_ch_state[i] <= CH_CLR_PEND;
              end else begin
                r_cnt[i]      <= r_dur[i];
                r_ch_state[i] <= CH_ACTIVE;
              end
            end else if (i_abort) begin
              if ((r_wr_state == WR_BUSY) && (r_wr_ch == PW'(i))) begin
                r_abort_hit[i] <= 1'b1;
              end else begin
                r_ch_state[i] <= CH_IDLE;
                r_done[i]     <= 1'b1;
              end
            end
          end
          CH_ACTIVE: begin
            if (i_abort) r_ch_state[i] <= CH_CLR_PEND;
            else if (w_tick) begin
              if (r_cnt[i] == DW'(1)) r_ch_state[i] <= CH_CLR_PEND;
              else                    r_cnt[i]      <= r_cnt[i] - 1'b1;
            end
          end
          default: if (w_accept && (r_wr_ch == PW'(i))) begin
            r_ch_state[i] <= CH_IDLE;
            r_done[i]     <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fluid_pio_pulse_sequencer.sv
// Directed bench for fluid_pio_pulse_sequencer: logs every accepted Avalon
// write and every done strobe, then checks order, data and timing per scenario.
module tb_fluid_pio_pulse_sequencer;
  localparam int NCH      = 4;
  localparam int DW       = 16;
  localparam int PRESCALE = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NCH-1:0]       req_valid = '0;
  logic [NCH-1:0]       req_ready;
  logic [NCH*16-1:0]    req_mask = '0;
  logic [NCH*DW-1:0]    req_dur = '0;
  logic                 abort = 1'b0;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       done;
  logic [2*NCH-1:0]     dbg_ch_state;
  logic [1:0]           dbg_wr_state;

  fluid_pio_pulse_sequencer_if bus();

  fluid_pio_pulse_sequencer #(.NCH(NCH), .DW(DW), .PRESCALE(PRESCALE)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_mask     (req_mask),
    .i_req_dur      (req_dur),
    .i_abort        (abort),
    .o_busy         (busy),
    .o_done         (done),
    .o_dbg_ch_state (dbg_ch_state),
    .o_dbg_wr_state (dbg_wr_state),
    .av             (bus.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard logs: accepted writes (address, data, accepting edge) and done strobes
  logic [2:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          done_cnt[NCH] = '{default: 0};

  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (bus.av_chipselect && !bus.av_write_n && !bus.av_waitrequest) begin
        log_addr.push_back(bus.av_address);
        log_data.push_back(bus.av_writedata);
        log_cyc.push_back(cyc + 1);
      end
      for (int i = 0; i < NCH; i++) if (done[i]) done_cnt[i]++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_req(input int ch, input logic [15:0] m, input logic [DW-1:0] d);
    req_mask[16*ch +: 16] = m;
    req_dur[DW*ch +: DW]  = d;
    req_valid[ch]         = 1'b1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    req_valid = '0;
    abort = 1'b0;
    bus.av_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #2;
  endtask

  task automatic wait_done(input int ch, input int target, input int max_cyc, output bit ok);
    int k = 0;
    while (done_cnt[ch] < target && k < max_cyc) begin
      @(negedge clk);
      #2;
      k++;
    end
    ok = (done_cnt[ch] >= target);
  endtask

  // tests
  task automatic test_reset;
    do_reset();
    checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL reset_ready: got %h, want f", req_ready); end
    checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %h, want 0", busy); end
    checks++; if (done !== 4'h0) begin errors++; $display("FAIL reset_done: got %h, want 0", done); end
    checks++; if (bus.av_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b, want 0", bus.av_chipselect); end
    checks++; if (bus.av_write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n: got %b, want 1", bus.av_write_n); end
    checks++; if (bus.av_address !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d, want 0", bus.av_address); end
    checks++; if (bus.av_writedata !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, want 0", bus.av_writedata); end
  endtask

  task automatic test_single_pulse;
    int b = log_addr.size();
    int d0 = done_cnt[0];
    int diff;
    bit ok;
    @(negedge clk); set_req(0, 16'h0003, 16'd2);
    @(negedge clk); req_valid = '0; #2;
    checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL single_ready_drop: got %b, want 0", req_ready[0]); end
    wait_done(0, d0 + 1, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout: done count %0d, want %0d", done_cnt[0], d0 + 1); end
    repeat (5) @(negedge clk); #2;
    checks++; if (log_addr.size() - b != 2) begin errors++; $display("FAIL single_write_count: got %0d, want 2", log_addr.size() - b); end
    if (log_addr.size() - b == 2) begin
      checks++; if (log_addr[b] !== 3'd4 || log_data[b] !== 32'h3) begin errors++; $display("FAIL single_set: addr %0d data %h, want 4 00000003", log_addr[b], log_data[b]); end
      checks++; if (log_addr[b+1] !== 3'd5 || log_data[b+1] !== 32'h3) begin errors++; $display("FAIL single_clr: addr %0d data %h, want 5 00000003", log_addr[b+1], log_data[b+1]); end
      diff = log_cyc[b+1] - log_cyc[b];
      checks++; if (diff < 7 || diff > 10) begin errors++; $display("FAIL single_pulse_len: got %0d cycles, want 7..10", diff); end
    end
    checks++; if (done_cnt[0] - d0 != 1) begin errors++; $display("FAIL single_done_once: got %0d, want 1", done_cnt[0] - d0); end
    checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL single_ready_back: got %h, want f", req_ready); end
  endtask

  task automatic test_zero_duration;
    int b = log_addr.size();
    int d0 = done_cnt[0];
    bit ok;
    @(negedge clk); set_req(0, 16'h8000, 16'd0);
    @(negedge clk); req_valid = '0;
    wait_done(0, d0 + 1, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dur0_done_timeout: done count %0d, want %0d", done_cnt[0], d0 + 1); end
    checks++; if (log_addr.size() - b != 2) begin errors++; $display("FAIL dur0_write_count: got %0d, want 2", log_addr.size() - b); end
    if (log_addr.size() - b == 2) begin
      checks++; if (log_addr[b] !== 3'd4 || log_data[b] !== 32'h8000) begin errors++; $display("FAIL dur0_set: addr %0d data %h, want 4 00008000", log_addr[b], log_data[b]); end
      checks++; if (log_addr[b+1] !== 3'd5 || log_data[b+1] !== 32'h8000) begin errors++; $display("FAIL dur0_clr: addr %0d data %h, want 5 00008000", log_addr[b+1], log_data[b+1]); end
      checks++; if (log_cyc[b+1] - log_cyc[b] != 3) begin errors++; $display("FAIL dur0_spacing: got %0d cycles, want 3", log_cyc[b+1] - log_cyc[b]); end
    end
  endtask

  task automatic test_all_channels;
    int b;
    int d[NCH];
    logic [31:0] exp_d;
    bit ok;
    do_reset();
    b = log_addr.size();
    for (int i = 0; i < NCH; i++) d[i] = done_cnt[i];
    @(negedge clk);
    for (int i = 0; i < NCH; i++) set_req(i, 16'h1 << i, 16'd5);
    @(negedge clk); req_valid = '0;
    wait_done(3, d[3] + 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL all_done_timeout: ch3 done count %0d, want %0d", done_cnt[3], d[3] + 1); end
    repeat (3) @(negedge clk); #2;
    checks++; if (log_addr.size() - b != 8) begin errors++; $display("FAIL all_write_count: got %0d, want 8", log_addr.size() - b); end
    if (log_addr.size() - b == 8) begin
      for (int j = 0; j < 4; j++) begin
        exp_d = 32'h1 << j;
        checks++; if (log_addr[b+j] !== 3'd4 || log_data[b+j] !== exp_d) begin errors++; $display("FAIL all_set_order[%0d]: addr %0d data %h, want 4 %h", j, log_addr[b+j], log_data[b+j], exp_d); end
        checks++; if (log_addr[b+4+j] !== 3'd5 || log_data[b+4+j] !== exp_d) begin errors++; $display("FAIL all_clr_order[%0d]: addr %0d data %h, want 5 %h", j, log_addr[b+4+j], log_data[b+4+j], exp_d); end
      end
      for (int j = 1; j < 8; j++) begin
        checks++; if (log_cyc[b+j] - log_cyc[b+j-1] < 3) begin errors++; $display("FAIL all_spacing[%0d]: got %0d cycles, want >= 3", j, log_cyc[b+j] - log_cyc[b+j-1]); end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      checks++; if (done_cnt[i] - d[i] != 1) begin errors++; $display("FAIL all_done[%0d]: got %0d, want 1", i, done_cnt[i] - d[i]); end
    end
  endtask

  task automatic test_waitrequest;
    int b = log_addr.size();
    int d1 = done_cnt[1];
    int k = 0;
    bit ok;
    bus.av_waitrequest = 1'b1;
    @(negedge clk); set_req(1, 16'h00F0, 16'd1);
    @(negedge clk); req_valid = '0; #2;
    while (bus.av_chipselect !== 1'b1 && k < 20) begin @(negedge clk); #2; k++; end
    checks++; if (bus.av_chipselect !== 1'b1) begin errors++; $display("FAIL wait_cs_timeout: cs %b, want 1", bus.av_chipselect); end
    for (int h = 0; h < 6; h++) begin
      checks++;
      if (bus.av_chipselect !== 1'b1 || bus.av_write_n !== 1'b0 || bus.av_address !== 3'd4 || bus.av_writedata !== 32'h00F0) begin
        errors++;
        $display("FAIL wait_hold[%0d]: cs %b wn %b addr %0d data %h, want 1 0 4 000000f0", h, bus.av_chipselect, bus.av_write_n, bus.av_address, bus.av_writedata);
      end
      @(negedge clk);
      if (h == 4) bus.av_waitrequest = 1'b0;
      #2;
    end
    checks++; if (log_addr.size() - b != 1 || bus.av_chipselect !== 1'b0) begin errors++; $display("FAIL wait_one_accept: writes %0d cs %b, want 1 0", log_addr.size() - b, bus.av_chipselect); end
    wait_done(1, d1 + 1, 40, ok);
    checks++; if (!ok || log_addr.size() - b != 2) begin errors++; $display("FAIL wait_finish: done %0d writes %0d, want %0d 2", done_cnt[1], log_addr.size() - b, d1 + 1); end
  endtask

  task automatic test_abort;
    int b = log_addr.size();
    int d[NCH];
    int abort_cyc;
    int k = 0;
    int n200 = 0;
    bit ok;
    for (int i = 0; i < NCH; i++) d[i] = done_cnt[i];
    @(negedge clk); set_req(0, 16'h0100, 16'd10);
    @(negedge clk); req_valid = '0;
    while (log_addr.size() == b && k < 20) begin @(negedge clk); #2; k++; end
    @(negedge clk); set_req(3, 16'h0800, 16'd0);
    @(negedge clk); req_valid = '0;
    wait_done(3, d[3] + 1, 30, ok);
    repeat (2) @(negedge clk); #2;
    checks++; if (!ok || log_addr.size() - b != 3 || busy[0] !== 1'b1) begin errors++; $display("FAIL abort_setup: writes %0d busy0 %b, want 3 1", log_addr.size() - b, busy[0]); end
    @(negedge clk); set_req(1, 16'h0200, 16'd3);
    @(negedge clk); req_valid = '0; set_req(2, 16'h0400, 16'd0); abort = 1'b1; abort_cyc = cyc + 1;
    @(negedge clk); req_valid = '0; abort = 1'b0;
    wait_done(2, d[2] + 1, 40, ok);
    repeat (3) @(negedge clk); #2;
    checks++; if (!ok) begin errors++; $display("FAIL abort_ch2_timeout: done count %0d, want %0d", done_cnt[2], d[2] + 1); end
    checks++; if (log_addr.size() - b != 6) begin errors++; $display("FAIL abort_write_count: got %0d, want 6", log_addr.size() - b); end
    if (log_addr.size() - b == 6) begin
      checks++; if (log_addr[b+3] !== 3'd5 || log_data[b+3] !== 32'h0100) begin errors++; $display("FAIL abort_ch0_clr: addr %0d data %h, want 5 00000100", log_addr[b+3], log_data[b+3]); end
      checks++; if (log_cyc[b+3] - abort_cyc > 3 || log_cyc[b+3] <= abort_cyc) begin errors++; $display("FAIL abort_ch0_latency: got %0d cycles, want 1..3", log_cyc[b+3] - abort_cyc); end
      checks++; if (log_addr[b+4] !== 3'd4 || log_data[b+4] !== 32'h0400) begin errors++; $display("FAIL abort_ch2_set: addr %0d data %h, want 4 00000400", log_addr[b+4], log_data[b+4]); end
      checks++; if (log_addr[b+5] !== 3'd5 || log_data[b+5] !== 32'h0400) begin errors++; $display("FAIL abort_ch2_clr: addr %0d data %h, want 5 00000400", log_addr[b+5], log_data[b+5]); end
    end
    for (int j = b; j < log_addr.size(); j++) if (log_data[j] == 32'h0200) n200++;
    checks++; if (n200 != 0) begin errors++; $display("FAIL abort_ch1_no_write: got %0d writes, want 0", n200); end
    checks++; if (done_cnt[1] - d[1] != 1) begin errors++; $display("FAIL abort_ch1_done: got %0d, want 1", done_cnt[1] - d[1]); end
    checks++; if (done_cnt[0] - d[0] != 1) begin errors++; $display("FAIL abort_ch0_done: got %0d, want 1", done_cnt[0] - d[0]); end
  endtask

  task automatic test_reset_mid_write;
    int b;
    int k = 0;
    bus.av_waitrequest = 1'b1;
    @(negedge clk); set_req(0, 16'h0001, 16'd0);
    @(negedge clk); req_valid = '0; #2;
    while (bus.av_chipselect !== 1'b1 && k < 20) begin @(negedge clk); #2; k++; end
    checks++; if (bus.av_chipselect !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_timeout: cs %b, want 1", bus.av_chipselect); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.av_chipselect !== 1'b0 || bus.av_write_n !== 1'b1) begin errors++; $display("FAIL rst_mid_ctrl: cs %b wn %b, want 0 1", bus.av_chipselect, bus.av_write_n); end
    checks++; if (bus.av_address !== 3'd0 || bus.av_writedata !== 32'h0) begin errors++; $display("FAIL rst_mid_bus: addr %0d data %h, want 0 0", bus.av_address, bus.av_writedata); end
    checks++; if (req_ready !== 4'hF || busy !== 4'h0 || done !== 4'h0) begin errors++; $display("FAIL rst_mid_status: ready %h busy %h done %h, want f 0 0", req_ready, busy, done); end
    bus.av_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    b = log_addr.size();
    repeat (20) @(negedge clk); #2;
    checks++; if (log_addr.size() - b != 0 || bus.av_chipselect !== 1'b0) begin errors++; $display("FAIL rst_mid_no_write: writes %0d cs %b, want 0 0", log_addr.size() - b, bus.av_chipselect); end
    checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL rst_mid_ready: got %h, want f", req_ready); end
  endtask

  initial begin
    bus.av_waitrequest = 1'b0;
    test_reset();
    test_single_pulse();
    test_zero_duration();
    test_all_channels();
    test_waitrequest();
    test_abort();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
